// File: rtl/ex_stage_muldiv.sv
// MIPS execute stage: operand forwarding, ALU decode, and an iterative
// multiply/divide unit with HI/LO that stalls the front end while busy.
module ex_stage_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_ex_valid,
  input  logic [31:0]       id_ex_instr,
  input  logic [1:0]        id_ex_alu_op,
  input  logic [DATA_W-1:0] id_ex_reg1,
  input  logic [DATA_W-1:0] id_ex_reg2,
  input  logic [DATA_W-1:0] id_ex_imm_value,
  input  logic              id_ex_alu_src,
  input  logic [DATA_W-1:0] ex_mem_alu_result,
  input  logic [DATA_W-1:0] mem_wb_write_back_result,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  output logic [DATA_W-1:0] alu_in2_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              muldiv_busy,
  output logic              ex_stall
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg2_if(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? ({(2*DATA_W){1'b0}} - v) : v;
  endfunction

  logic [DATA_W-1:0]        op_a, fwd_b, op_b;
  logic signed [DATA_W-1:0] a_s, b_s;
  logic [5:0]               funct;
  logic [4:0]               shamt;
  logic [SH_W-1:0]          sh_amt;
  logic                     rtype, is_md, is_hilo_rd, start;
  logic [DATA_W-1:0]        res;
  logic                     unused_instr;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic              is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d, dz_q, dz_d;

  logic [DATA_W:0]     mul_sum;
  logic                div_ge;
  logic [DATA_W-1:0]   div_keep, div_diff;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod;
  logic                sgn_op;

  assign funct        = id_ex_instr[5:0];
  assign shamt        = id_ex_instr[10:6];
  assign sh_amt       = SH_W'(shamt);
  assign unused_instr = ^id_ex_instr[31:11];

  always_comb begin
    case (forward_a)
      2'b01:   op_a = mem_wb_write_back_result;
      2'b10:   op_a = ex_mem_alu_result;
      default: op_a = id_ex_reg1;
    endcase
    case (forward_b)
      2'b01:   fwd_b = mem_wb_write_back_result;
      2'b10:   fwd_b = ex_mem_alu_result;
      default: fwd_b = id_ex_reg2;
    endcase
    op_b = id_ex_alu_src ? id_ex_imm_value : fwd_b;
  end

  assign alu_in2_out = fwd_b;
  assign a_s         = op_a;
  assign b_s         = op_b;

  assign rtype      = id_ex_valid && (id_ex_alu_op == 2'b10);
  assign is_md      = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
  assign is_hilo_rd = (funct == F_MFHI) || (funct == F_MFLO);

  assign muldiv_busy = (cnt_q != '0);
  assign start       = rtype && is_md && !muldiv_busy;
  assign ex_stall    = muldiv_busy && rtype && (is_md || is_hilo_rd);

  always_comb begin
    res = '0;
    case (id_ex_alu_op)
      2'b00: res = op_a + op_b;
      2'b01: res = op_a - op_b;
      2'b11: res = op_a | op_b;
      default: begin
        case (funct)
          F_ADD, F_ADDU: res = op_a + op_b;
          F_SUB, F_SUBU: res = op_a - op_b;
          F_AND:  res = op_a & op_b;
          F_OR:   res = op_a | op_b;
          F_XOR:  res = op_a ^ op_b;
          F_NOR:  res = ~(op_a | op_b);
          F_SLT:  res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
          F_SLTU: res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
          F_SLL:  res = op_b << sh_amt;
          F_SRL:  res = op_b >> sh_amt;
          F_SRA:  res = b_s >>> sh_amt;
          F_MFHI: res = hi_q;
          F_MFLO: res = lo_q;
          default: res = '0;
        endcase
      end
    endcase
  end

  assign alu_result = res;
  assign zero       = (res == '0);

  // One shift-add or restoring-subtract step per busy cycle, on magnitudes.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + ({1'b0, opnd_q} & {(DATA_W+1){acc_lo_q[0]}});
    div_keep = {acc_hi_q[DATA_W-2:0], acc_lo_q[DATA_W-1]};
    div_ge   = ({acc_hi_q, acc_lo_q[DATA_W-1]} >= {1'b0, opnd_q});
    div_diff = div_keep - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_keep;
      step_lo = {acc_lo_q[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end
    prod = neg2_if({step_hi, step_lo}, neg_res_q);
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    sgn_op    = ~funct[0];
    if (start) begin
      cnt_d     = CNT_W'(DATA_W);
      is_div_d  = funct[1];
      acc_hi_d  = '0;
      acc_lo_d  = neg_if(op_a, sgn_op && op_a[DATA_W-1]);
      opnd_d    = neg_if(fwd_b, sgn_op && fwd_b[DATA_W-1]);
      neg_res_d = sgn_op && (op_a[DATA_W-1] ^ fwd_b[DATA_W-1]);
      neg_rem_d = sgn_op && op_a[DATA_W-1];
      dz_d      = (fwd_b == '0);
    end else if (muldiv_busy) begin
      cnt_d    = cnt_q - CNT_W'(1);
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      if (cnt_q == CNT_W'(1)) begin
        if (is_div_q) begin
          lo_d = dz_q ? '1 : neg_if(step_lo, neg_res_q);
          hi_d = neg_if(step_hi, neg_rem_q);
        end else begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
      end
    end
  end

  // Reset aborts any operation in flight; HI/LO keep only completed results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Bench for ex_stage_muldiv: table-driven ALU vectors, directed mul/div and
// hazard/reset sequences, and randomized checks against a plain-arithmetic model.
module tb_ex_stage_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ex_valid;
  logic [31:0] id_ex_instr;
  logic [1:0]  id_ex_alu_op;
  logic [31:0] id_ex_reg1, id_ex_reg2, id_ex_imm_value;
  logic        id_ex_alu_src;
  logic [31:0] ex_mem_alu_result, mem_wb_write_back_result;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] alu_in2_out, alu_result;
  logic        zero, muldiv_busy, ex_stall;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always #5 clk = ~clk;

  ex_stage_muldiv #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .id_ex_instr(id_ex_instr),
    .id_ex_alu_op(id_ex_alu_op), .id_ex_reg1(id_ex_reg1), .id_ex_reg2(id_ex_reg2),
    .id_ex_imm_value(id_ex_imm_value), .id_ex_alu_src(id_ex_alu_src),
    .ex_mem_alu_result(ex_mem_alu_result), .mem_wb_write_back_result(mem_wb_write_back_result),
    .forward_a(forward_a), .forward_b(forward_b), .alu_in2_out(alu_in2_out),
    .alu_result(alu_result), .zero(zero), .muldiv_busy(muldiv_busy), .ex_stall(ex_stall)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] r1, r2, imm;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] exp_res, exp_in2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    id_ex_valid     = v;
    id_ex_alu_op    = op;
    id_ex_instr     = {21'h0, sh, f};
    id_ex_reg1      = a;
    id_ex_reg2      = b;
    id_ex_imm_value = 32'h0;
    id_ex_alu_src   = 1'b0;
    forward_a       = 2'b00;
    forward_b       = 2'b00;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] r,
                                      input logic [31:0] exm, input logic [31:0] mwb);
    if (s == 2'b01) return mwb;
    if (s == 2'b10) return exm;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [5:0] f,
      input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] hi, input logic [31:0] lo);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: case (f)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: return (a < b) ? 32'd1 : 32'd0;
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return sb >>> sh;
        6'h10: return hi;
        6'h12: return lo;
        default: return 32'h0;
      endcase
    endcase
  endfunction

  task automatic md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    longint p;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (f)
      6'h18: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
      6'h19: begin pu = {32'h0, a} * {32'h0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      6'h1A: begin
        if (b == 32'h0) begin lo = 32'hFFFFFFFF; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = a; hi = 32'h0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 32'h0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // Issue one mul/div, count busy cycles (bounded), then read HI and LO back.
  task automatic md_run(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    drive(1'b1, 2'b10, f, 5'd0, a, b);
    @(negedge clk);
    idle();
    n = 0;
    while (muldiv_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, 32'(n), 32'd32);
    drive(1'b1, 2'b10, 6'h10, 5'd0, 32'h0, 32'h0);
    #1 check({name, "_hi"}, alu_result, exp_hi);
    drive(1'b1, 2'b10, 6'h12, 5'd0, 32'h0, 32'h0);
    #1 check({name, "_lo"}, alu_result, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    vec_t tbl[17];
    logic [5:0] flist[16];
    logic [31:0] specials[4];
    logic [31:0] ehi, elo, a, b, exm, mwb, opa, fb;
    int stall_cnt;

    tbl[0]  = '{2'b00, 6'h00, 5'd0, 32'd1, 32'd2, 32'h0, 1'b0, 2'b10, 2'b00, 32'd7, 32'd2};
    tbl[1]  = '{2'b00, 6'h00, 5'd0, 32'd1, 32'd2, 32'h0, 1'b0, 2'b01, 2'b00, 32'd11, 32'd2};
    tbl[2]  = '{2'b00, 6'h00, 5'd0, 32'd1, 32'd2, 32'h100, 1'b1, 2'b00, 2'b10, 32'h101, 32'd5};
    tbl[3]  = '{2'b10, 6'h2A, 5'd0, 32'hFFFFFFF0, 32'd3, 32'h0, 1'b0, 2'b00, 2'b00, 32'd1, 32'd3};
    tbl[4]  = '{2'b10, 6'h2B, 5'd0, 32'hFFFFFFF0, 32'd3, 32'h0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd3};
    tbl[5]  = '{2'b10, 6'h27, 5'd0, 32'hFFFFFFF0, 32'd3, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0000000C, 32'd3};
    tbl[6]  = '{2'b10, 6'h03, 5'd4, 32'h0, 32'h80000000, 32'h0, 1'b0, 2'b00, 2'b00, 32'hF8000000, 32'h80000000};
    tbl[7]  = '{2'b01, 6'h00, 5'd0, 32'd3, 32'd5, 32'h0, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd5};
    tbl[8]  = '{2'b11, 6'h00, 5'd0, 32'hF0, 32'h0F, 32'h0, 1'b0, 2'b00, 2'b00, 32'hFF, 32'h0F};
    tbl[9]  = '{2'b10, 6'h00, 5'd4, 32'h0, 32'd3, 32'h0, 1'b0, 2'b00, 2'b00, 32'h30, 32'd3};
    tbl[10] = '{2'b10, 6'h02, 5'd4, 32'h0, 32'h80000000, 32'h0, 1'b0, 2'b00, 2'b00, 32'h08000000, 32'h80000000};
    tbl[11] = '{2'b10, 6'h3F, 5'd0, 32'd7, 32'd9, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'd9};
    tbl[12] = '{2'b10, 6'h26, 5'd0, 32'hFF00, 32'h0FF0, 32'h0, 1'b0, 2'b00, 2'b00, 32'hF0F0, 32'h0FF0};
    tbl[13] = '{2'b10, 6'h24, 5'd0, 32'hFF00, 32'h0FF0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0F00, 32'h0FF0};
    tbl[14] = '{2'b10, 6'h23, 5'd0, 32'd20, 32'd1, 32'h0, 1'b0, 2'b00, 2'b01, 32'd11, 32'd9};
    tbl[15] = '{2'b00, 6'h00, 5'd0, 32'd1, 32'd2, 32'h0, 1'b0, 2'b00, 2'b11, 32'd3, 32'd2};
    tbl[16] = '{2'b10, 6'h10, 5'd0, 32'd1, 32'd2, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'd2};

    flist = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3F};
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};

    reset = 1'b1;
    ex_mem_alu_result = 32'd5;
    mem_wb_write_back_result = 32'd9;
    drive(1'b1, 2'b10, 6'h10, 5'd0, 32'h0, 32'h0);
    #1;
    check("reset_busy", 32'(muldiv_busy), 32'd0);
    check("reset_stall", 32'(ex_stall), 32'd0);
    check("reset_hi", alu_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].op, tbl[i].f, tbl[i].sh, tbl[i].r1, tbl[i].r2);
      id_ex_imm_value = tbl[i].imm;
      id_ex_alu_src   = tbl[i].src;
      forward_a       = tbl[i].fa;
      forward_b       = tbl[i].fb;
      #1;
      check($sformatf("tbl%0d_result", i), alu_result, tbl[i].exp_res);
      check($sformatf("tbl%0d_in2", i), alu_in2_out, tbl[i].exp_in2);
      check($sformatf("tbl%0d_zero", i), 32'(zero), 32'(tbl[i].exp_res == 32'h0));
    end

    md_run("mult_7x-3", 6'h18, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_run("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
    md_run("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    md_run("div_-7_2", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("div_by0", 6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    md_run("divu_by0", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    md_run("div_min_m1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // mult then mflo held in the shadow, with one independent add at cycle 5
    @(negedge clk);
    drive(1'b1, 2'b10, 6'h18, 5'd0, 32'd7, 32'd5);
    #1 check("hz_start_nostall", 32'(ex_stall), 32'd0);
    stall_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 5) drive(1'b1, 2'b10, 6'h20, 5'd0, 32'd3, 32'd4);
      else        drive(1'b1, 2'b10, 6'h12, 5'd0, 32'h0, 32'h0);
      #1;
      if (ex_stall) stall_cnt++;
      if (c == 5) begin
        check("hz_add_nostall", 32'(ex_stall), 32'd0);
        check("hz_add_result", alu_result, 32'd7);
      end
      if (c == 33) begin
        check("hz_mflo_nostall", 32'(ex_stall), 32'd0);
        check("hz_mflo_value", alu_result, 32'd35);
      end
    end
    check("hz_stall_cycles", 32'(stall_cnt), 32'd31);
    m_hi = 32'h0;
    m_lo = 32'd35;

    // back-to-back: divu held behind a mult starts in cycle 33
    @(negedge clk);
    drive(1'b1, 2'b10, 6'h18, 5'd0, 32'hFFFFFFFE, 32'd3);
    stall_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      drive(1'b1, 2'b10, 6'h1B, 5'd0, 32'd100, 32'd7);
      #1;
      if (ex_stall) stall_cnt++;
    end
    check("b2b_stall_cycles", 32'(stall_cnt), 32'd32);
    @(negedge clk);
    idle();
    check("b2b_second_busy", 32'(muldiv_busy), 32'd1);
    for (int c = 0; c < 31; c++) @(negedge clk);
    check("b2b_second_last", 32'(muldiv_busy), 32'd1);
    @(negedge clk);
    check("b2b_second_done", 32'(muldiv_busy), 32'd0);
    drive(1'b1, 2'b10, 6'h12, 5'd0, 32'h0, 32'h0);
    #1 check("b2b_lo", alu_result, 32'd14);
    m_hi = 32'd2;
    m_lo = 32'd14;

    // reset in cycle 10 of a div
    @(negedge clk);
    drive(1'b1, 2'b10, 6'h1A, 5'd0, 32'd1000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      drive(1'b1, 2'b10, 6'h12, 5'd0, 32'h0, 32'h0);
    end
    #1 check("rst_pre_stall", 32'(ex_stall), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(muldiv_busy), 32'd0);
    check("rst_stall", 32'(ex_stall), 32'd0);
    check("rst_lo", alu_result, 32'h0);
    drive(1'b1, 2'b10, 6'h10, 5'd0, 32'h0, 32'h0);
    #1 check("rst_hi", alu_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    md_run("post_rst_mult", 6'h18, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);

    for (int i = 0; i < 16; i++) begin
      logic [5:0] f;
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      md_ref(f, a, b, ehi, elo);
      md_run($sformatf("rnd_md%0d", i), f, a, b, ehi, elo);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op, fa, fbs;
      logic [5:0] f;
      logic [4:0] sh;
      logic src;
      logic [31:0] imm;
      op = 2'($urandom_range(0, 3));
      f = flist[$urandom_range(0, 15)];
      sh = 5'($urandom);
      fa = 2'($urandom);
      fbs = 2'($urandom);
      src = 1'($urandom);
      a = $urandom;
      b = $urandom;
      imm = $urandom;
      exm = $urandom;
      mwb = $urandom;
      @(negedge clk);
      drive(1'($urandom), op, f, sh, a, b);
      id_ex_imm_value = imm;
      id_ex_alu_src = src;
      forward_a = fa;
      forward_b = fbs;
      ex_mem_alu_result = exm;
      mem_wb_write_back_result = mwb;
      opa = sel(fa, a, exm, mwb);
      fb = sel(fbs, b, exm, mwb);
      elo = alu_ref(op, f, sh, opa, src ? imm : fb, m_hi, m_lo);
      #1;
      check($sformatf("rnd_alu%0d_result", i), alu_result, elo);
      check($sformatf("rnd_alu%0d_in2", i), alu_in2_out, fb);
      check($sformatf("rnd_alu%0d_zero", i), 32'(zero), 32'(elo == 32'h0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage_muldiv.md
# ex_stage_muldiv

Parametrised execute stage for the 5-stage MIPS pipeline. Sits between the ID/EX and EX/MEM registers. It does the following:
- resolves operand forwarding;
- selects the second operand between register and immediate;
- decodes ALU control from alu_op/funct;
- adds an iterative multiply/divide unit with HI/LO registers, and stalls the front end while that unit is busy.

Single-cycle ALU results stay combinational. Multiply/divide are multi-cycle and sequential.

## Interface
- DATA_W, 32, datapath width (≥8, power of two); also the multiply/divide iteration count
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_ex_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- id_ex_instr  in  32  instruction; funct = [5:0], shamt = [10:6]
- id_ex_alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 or
- id_ex_reg1, id_ex_reg2  in  DATA_W  register-file operands
- id_ex_imm_value  in  DATA_W  extended immediate
- id_ex_alu_src  in  1  1 = second ALU operand is immediate
- ex_mem_alu_result  in  DATA_W  forward source, EX/MEM
- mem_wb_write_back_result  in  DATA_W  forward source, MEM/WB
- forward_a, forward_b  in  2  00 reg, 01 MEM/WB, 10 EX/MEM, 11 reg
- alu_in2_out  out  DATA_W  forwarded reg2 (store data), before the alu_src mux
- alu_result  out  DATA_W  result
- zero  out  1  alu_result == 0
- muldiv_busy  out  1  unit iterating
- ex_stall  out  1  hold PC, IF/ID, ID/EX; bubble into EX/MEM

## Operation
- Operand A is forward_a mux output. Operand B is forward_b mux output, or the immediate when id_ex_alu_src=1.
- R-type funct decode:
  - 20/21 add; 22/23 sub (no overflow trap)
  - 24 and; 25 or; 26 xor; 27 nor
  - 2A slt (signed); 2B sltu
  - 00 sll, 02 srl, 03 sra: operand B shifted by shamt[log2(DATA_W)-1:0]
  - 10 mfhi → HI; 12 mflo → LO
  - 18 mult, 19 multu, 1A div, 1B divu → alu_result 0
  - unknown funct → 0
- Arithmetic is modulo 2^DATA_W.
- Start condition: id_ex_valid & alu_op=10 & funct ∈ {18,19,1A,1B} & !muldiv_busy.
  - On that edge the unit latches operand A, forwarded B, and the opcode.
  - The cycle counter loads DATA_W.
- Mult: shift-add, one bit per cycle, producing a 2·DATA_W product; HI = upper half, LO = lower half.
  - Signed mult works on magnitudes and negates the 2·DATA_W product when the signs differ.
- Div: restoring, one quotient bit per cycle; LO = quotient, HI = remainder.
  - Signed div works on magnitudes. The quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Divide by zero (both div and divu): LO = all ones, HI = dividend. No trap.
- Signed MIN / −1: LO = MIN, HI = 0.
- ex_stall = muldiv_busy & id_ex_valid & alu_op=10 & funct ∈ {10,12,18,19,1A,1B}.
- While the unit is busy, other instructions proceed without stalling.
- A stalled mult/div starts on the first cycle busy=0.
- HI/LO change only at completion. There is no MTHI/MTLO.

## Timing
- Reset (async): HI=0, LO=0, counter=0, muldiv_busy=0, ex_stall=0.
  - A reset mid-operation aborts the operation; HI/LO are not updated from the partial result.
- alu_result, zero, alu_in2_out and ex_stall are combinational from the current inputs and state, with no added latency.
- Start edge ends cycle 0. muldiv_busy is high for cycles 1..DATA_W (counter decrements each cycle).
- HI/LO are written at the edge ending cycle DATA_W. mfhi/mflo read the new value in cycle DATA_W+1.
- Back-to-back mult/div: the second one stalls through cycle DATA_W and starts in cycle DATA_W+1.
- Starts are ignored while id_ex_valid=0.

## Test plan
- Forwarding: reg1=1, ex_mem=5, mem_wb=9, add.
  - forward_a=10 → 5+reg2; forward_a=01 → 9+reg2.
  - forward_b=10 with alu_src=1 → imm is used and alu_in2_out = 5.
- R-type sweep: A=0xFFFFFFF0, B=3.
  - slt=1, sltu=0, nor=0x0000000C.
  - sra with shamt 4 on B=0x80000000 → 0xF8000000.
- mult, 7 × −3 (DATA_W=32): busy exactly 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - multu, 0xFFFFFFFF²: HI=0xFFFFFFFE, LO=1.
- divu 100/7 → LO=14, HI=2.
  - div −7/2 → LO=−3, HI=−1.
  - div by 0 with 5 → LO=0xFFFFFFFF, HI=5.
  - div 0x80000000 / −1 → LO=0x80000000, HI=0.
- Hazard: mult followed immediately by mflo.
  - ex_stall is high cycles 1..32; an add issued in between is not stalled.
  - mflo returns the product in cycle 33.
- Reset asserted at cycle 10 of a div: busy, stall, HI and LO all read 0 immediately; a new mult after reset completes correctly.
